ddr2_rd_scheduler: RTL and testbench

- Sequences DDR2 read traffic from the MIG user interface into the read-data FIFO.
- Accepts one read job at a time: start address plus length in bursts.
- Issues read commands on the MIG address/command FIFO interface.
- Throttles issue on the MIG af_afull flag, on read-FIFO almost_full, and on a bound of outstanding (issued but not yet returned) bursts.
- Sits in the memory-clock domain, upstream of the read FIFO's write port.

---
 rtl/ddr2_rd_sched_pkg.sv | 21 ++
 rtl/ddr2_rd_credit_cnt.sv | 46 ++++
 rtl/ddr2_rd_scheduler.sv | 119 +++++++++++
 tb/tb_ddr2_rd_scheduler.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_rd_sched_pkg.sv
// ddr2_rd_sched_pkg: shared state encoding, command code and width helper for the DDR2 read scheduler
package ddr2_rd_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [2:0] CMD_READ = 3'b001;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/ddr2_rd_credit_cnt.sv
// ddr2_rd_credit_cnt: read-beat counter and issued-but-unreturned burst counter
module ddr2_rd_credit_cnt
    import ddr2_rd_sched_pkg::*;
#(
    parameter int BEATS_PER_BURST = 2,
    parameter int MAX_OUTSTANDING = 8,
    parameter int OW              = clog2(MAX_OUTSTANDING) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          issue_i,
    input  logic          beat_i,
    output logic [OW-1:0] outstanding_o,
    output logic          beat_zero_o
);

    localparam int BW = (clog2(BEATS_PER_BURST) > 0) ? clog2(BEATS_PER_BURST) : 1;

    logic [BW-1:0] beat_q, beat_d;
    logic [OW-1:0] out_q, out_d;
    logic          ret, inc, dec;

    // A burst returns on the beat that wraps the counter; a return with nothing outstanding is dropped
    always_comb begin
        ret    = beat_i && (beat_q == BW'(BEATS_PER_BURST - 1));
        beat_d = beat_i ? (ret ? '0 : beat_q + BW'(1)) : beat_q;
        inc    = issue_i && (out_q < OW'(MAX_OUTSTANDING));
        dec    = ret && (out_q != '0);
        out_d  = (inc && !dec) ? out_q + OW'(1) : (!inc && dec) ? out_q - OW'(1) : out_q;
    end

    // Counter state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_q <= '0;
            out_q  <= '0;
        end else begin
            beat_q <= beat_d;
            out_q  <= out_d;
        end
    end

    assign outstanding_o = out_q;
    assign beat_zero_o   = (beat_q == '0);

endmodule

// File: rtl/ddr2_rd_scheduler.sv
// ddr2_rd_scheduler: issues MIG read commands for one job at a time with credit-based throttling; optional counters under DDR2_RD_SCHED_STATS_EN
module ddr2_rd_scheduler
    import ddr2_rd_sched_pkg::*;
#(
    parameter int ADDR_WIDTH      = 31,
    parameter int LEN_WIDTH       = 16,
    parameter int BEATS_PER_BURST = 2,
    parameter int ADDR_STEP       = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [ADDR_WIDTH-1:0]             req_addr,
    input  logic [LEN_WIDTH-1:0]              req_len,
    input  logic                              af_afull,
    output logic                              app_af_wren,
    output logic [2:0]                        app_af_cmd,
    output logic [ADDR_WIDTH-1:0]             app_af_addr,
    input  logic                              rd_data_valid,
    input  logic                              fifo_almost_full,
    output logic [clog2(MAX_OUTSTANDING):0]   outstanding,
`ifdef DDR2_RD_SCHED_STATS_EN
    output logic [31:0]                       stall_cycles,
    output logic [31:0]                       burst_count,
`endif
    output logic                              busy,
    output logic                              done
);

    localparam int OW = clog2(MAX_OUTSTANDING) + 1;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, af_addr_q;
    logic [LEN_WIDTH-1:0]    rem_q;
    logic                    wren_q, done_q, busy_q, ready_q;
    logic                    issue, beat_zero;

    ddr2_rd_credit_cnt #(
        .BEATS_PER_BURST(BEATS_PER_BURST),
        .MAX_OUTSTANDING(MAX_OUTSTANDING),
        .OW             (OW)
    ) u_credit (
        .clk          (clk),
        .reset_n      (reset_n),
        .issue_i      (issue),
        .beat_i       (rd_data_valid),
        .outstanding_o(outstanding),
        .beat_zero_o  (beat_zero)
    );

    // Issue qualifier and next-state selection
    always_comb begin
        issue   = (state_q == ISSUE) && !af_afull && !fifo_almost_full && (outstanding < OW'(MAX_OUTSTANDING));
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = (req_len == '0) ? DONE : ISSUE;
            ISSUE:   if (issue && rem_q == LEN_WIDTH'(1)) state_d = DRAIN;
            DRAIN:   if (outstanding == '0 && beat_zero) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // FSM, address generation and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            af_addr_q <= '0;
            wren_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            ready_q <= (state_d == IDLE);
            done_q  <= (state_q == DONE);
            wren_q  <= issue;
            if (state_q == IDLE && req_valid) begin
                addr_q <= req_addr;
                rem_q  <= req_len;
            end
            if (issue) begin
                af_addr_q <= addr_q;
                addr_q    <= addr_q + ADDR_WIDTH'(ADDR_STEP);
                rem_q     <= rem_q - LEN_WIDTH'(1);
            end
        end
    end

`ifdef DDR2_RD_SCHED_STATS_EN
    logic [31:0] stall_q, burst_q;

    // Stall counter saturates; burst counter wraps
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
            burst_q <= '0;
        end else begin
            if (state_q == ISSUE && !issue && stall_q != '1) stall_q <= stall_q + 32'd1;
            if (issue) burst_q <= burst_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign burst_count  = burst_q;
`endif

    assign req_ready   = ready_q;
    assign app_af_wren = wren_q;
    assign app_af_cmd  = CMD_READ;
    assign app_af_addr = af_addr_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_ddr2_rd_scheduler.sv
// tb_ddr2_rd_scheduler: scoreboard bench for the DDR2 read scheduler
module tb_ddr2_rd_scheduler;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [30:0] req_addr = '0;
    logic [15:0] req_len = '0;
    logic        af_afull = 1'b0;
    logic        rd_data_valid = 1'b0;
    logic        fifo_almost_full = 1'b0;
    logic        req_ready, app_af_wren, busy, done;
    logic [2:0]  app_af_cmd;
    logic [30:0] app_af_addr;
    logic [3:0]  outstanding;

    ddr2_rd_scheduler dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_addr        (req_addr),
        .req_len         (req_len),
        .af_afull        (af_afull),
        .app_af_wren     (app_af_wren),
        .app_af_cmd      (app_af_cmd),
        .app_af_addr     (app_af_addr),
        .rd_data_valid   (rd_data_valid),
        .fifo_almost_full(fifo_almost_full),
        .outstanding     (outstanding),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [30:0] obs[$];
    int          obs_cyc[$];
    logic [30:0] exp_q[$];
    int          oi = 0;
    int          ncyc = 0;
    int          done_cnt = 0, beat_cnt = 0, beats_at_done = 0, viol = 0;
    int          man_req = 0, man_done = 0, apend = 0;
    bit          auto_ret = 1'b0, stall_prev = 1'b0;
    logic [3:0]  dly = '0;

    // Monitor and memory model: records commands, returns beats, flags commands issued under stall
    always @(negedge clk) begin
        ncyc++;
        if (app_af_wren) begin
            obs.push_back(app_af_addr);
            obs_cyc.push_back(ncyc);
            if (stall_prev) viol++;
        end
        if (done) begin
            done_cnt++;
            beats_at_done = beat_cnt;
        end
        stall_prev = af_afull | fifo_almost_full;
        if (!reset_n) begin
            dly = '0;
            apend = 0;
            man_done = man_req;
            rd_data_valid = 1'b0;
        end else begin
            dly = {dly[2:0], app_af_wren & auto_ret};
            if (dly[3]) apend += 2;
            if (man_done != man_req) begin
                rd_data_valid = 1'b1;
                man_done++;
            end else if (apend > 0) begin
                rd_data_valid = 1'b1;
                apend--;
            end else begin
                rd_data_valid = 1'b0;
            end
            if (rd_data_valid) beat_cnt++;
        end
    end

    task automatic push_exp(input logic [30:0] a, input int n);
        logic [30:0] x;
        x = a;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(x);
            x = x + 31'd4;
        end
    endtask

    task automatic cmp_obs(input string tag);
        logic [30:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (oi < obs.size()) begin
                check(tag, 64'(obs[oi]), 64'(e));
                oi++;
            end else begin
                check({tag, "_missing"}, 64'(obs.size()), 64'(oi + 1));
            end
        end
        check({tag, "_extra"}, 64'(obs.size()), 64'(oi));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [30:0] a, input logic [15:0] l);
        int t;
        t = 0;
        while (!req_ready && t < 100) begin
            cyc(1);
            t++;
        end
        check("req_ready_wait", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        cyc(1);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int c0, t;
        c0 = done_cnt;
        t = 0;
        while (done_cnt == c0 && t < budget) begin
            cyc(1);
            t++;
        end
        check(tag, 64'(done_cnt - c0), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, d0, n0, v0, na;
        cyc(3);
        check("rst_wren", 64'(app_af_wren), 64'd0);
        check("rst_addr", 64'(app_af_addr), 64'd0);
        check("rst_cmd", 64'(app_af_cmd), 64'd1);
        check("rst_outstanding", 64'(outstanding), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        reset_n = 1'b1;
        cyc(1);
        check("rst_ready", 64'(req_ready), 64'd1);

        // Basic 3-burst job with returning data
        auto_ret = 1'b1;
        b0 = beat_cnt;
        d0 = done_cnt;
        push_exp(31'h100, 3);
        start_job(31'h100, 16'd3);
        wait_done("t1_done", 100);
        check("t1_beats_at_done", 64'(beats_at_done - b0), 64'd6);
        if (oi + 2 < obs.size()) check("t1_consecutive", 64'(obs_cyc[oi + 2] - obs_cyc[oi]), 64'd2);
        else check("t1_cmd_count", 64'(obs.size() - oi), 64'd3);
        cmp_obs("t1_addr");
        cyc(4);
        check("t1_single_done", 64'(done_cnt - d0), 64'd1);
        check("t1_outstanding", 64'(outstanding), 64'd0);
        check("t1_busy", 64'(busy), 64'd0);

        // Zero-length job
        start_job(31'h200, 16'd0);
        check("t2_done_e0", 64'(done), 64'd0);
        check("t2_ready_e0", 64'(req_ready), 64'd0);
        check("t2_busy_e0", 64'(busy), 64'd1);
        cyc(1);
        check("t2_done_e1", 64'(done), 64'd1);
        check("t2_ready_e1", 64'(req_ready), 64'd1);
        check("t2_busy_e1", 64'(busy), 64'd0);
        cyc(1);
        check("t2_done_e2", 64'(done), 64'd0);
        check("t2_no_cmd", 64'(obs.size()), 64'(oi));

        // Outstanding bound with no data returned
        auto_ret = 1'b0;
        n0 = obs.size();
        push_exp(31'h2000, 20);
        start_job(31'h2000, 16'd20);
        cyc(15);
        check("t3_cmds_at_limit", 64'(obs.size() - n0), 64'd8);
        check("t3_outstanding_max", 64'(outstanding), 64'd8);
        check("t3_stalled_wren", 64'(app_af_wren), 64'd0);
        man_req += 2;
        cyc(10);
        check("t3_one_more_cmd", 64'(obs.size() - n0), 64'd9);
        check("t3_outstanding_after", 64'(outstanding), 64'd8);
        man_req += 38;
        wait_done("t3_done", 400);
        cmp_obs("t3_addr");

        // af_afull and fifo_almost_full stalls
        auto_ret = 1'b1;
        v0 = viol;
        push_exp(31'h3000, 12);
        start_job(31'h3000, 16'd12);
        cyc(2);
        af_afull = 1'b1;
        cyc(1);
        na = obs.size();
        cyc(4);
        check("t4_afull_hold", 64'(obs.size()), 64'(na));
        af_afull = 1'b0;
        cyc(1);
        fifo_almost_full = 1'b1;
        cyc(3);
        fifo_almost_full = 1'b0;
        wait_done("t4_done", 300);
        check("t4_cmd_under_stall", 64'(viol - v0), 64'd0);
        cmp_obs("t4_addr");

        // Issue and burst return on the same edge
        auto_ret = 1'b0;
        af_afull = 1'b1;
        push_exp(31'h4000, 2);
        start_job(31'h4000, 16'd2);
        cyc(2);
        check("t5_held", 64'(outstanding), 64'd0);
        af_afull = 1'b0;
        cyc(1);
        af_afull = 1'b1;
        check("t5_first_issue", 64'(outstanding), 64'd1);
        man_req += 1;
        cyc(1);
        check("t5_half_burst", 64'(outstanding), 64'd1);
        man_req += 1;
        af_afull = 1'b0;
        cyc(1);
        af_afull = 1'b1;
        check("t5_simultaneous", 64'(outstanding), 64'd1);
        af_afull = 1'b0;
        man_req += 2;
        wait_done("t5_done", 100);
        cmp_obs("t5_addr");

        // Asynchronous reset mid-ISSUE
        start_job(31'h5000, 16'd10);
        cyc(3);
        check("t6_pre_outstanding", 64'(outstanding), 64'd3);
        @(posedge clk);
        #1;
        check("t6_pre_wren", 64'(app_af_wren), 64'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("t6_async_wren", 64'(app_af_wren), 64'd0);
        check("t6_async_outstanding", 64'(outstanding), 64'd0);
        check("t6_async_busy", 64'(busy), 64'd0);
        cyc(2);
        reset_n = 1'b1;
        oi = obs.size();
        check("t6_ready_after", 64'(req_ready), 64'd1);
        auto_ret = 1'b1;
        push_exp(31'h6000, 2);
        start_job(31'h6000, 16'd2);
        wait_done("t6_done", 100);
        cmp_obs("t6_addr");

        // Address wrap at the top of the address space
        exp_q.push_back(31'h7FFFFFFC);
        exp_q.push_back(31'h00000000);
        start_job(31'h7FFFFFFC, 16'd2);
        wait_done("t7_done", 100);
        cmp_obs("t7_addr");

        cyc(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
